// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: fetch FSM encoding,
// NOP/HALT instruction words and the program-loader byte counter width.
package mips_pkg;

  localparam logic [31:0]  NOP        = 32'h0000_0000;
  localparam logic [31:0]  HALT       = 32'hFFFF_FFFF;
  localparam int unsigned  BYTE_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
module instr_mem #(
  parameter int unsigned SIZE_INSTR = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [SIZE_INSTR-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [SIZE_INSTR-1:0] o_rdata
);

  logic [SIZE_INSTR-1:0] mem_q [MEM_DEPTH];

  // NOTE: the storage array has no reset; clearing it would turn the RAM into
  // a large flop bank, and a fresh program load overwrites it anyway.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: byte-serial program loader, instruction memory and
// the IF/ID pipeline register. Define IF_ADDR_CHECK_EN to trap out-of-range PCs.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned SIZE_ADDR_PC = 32,
  parameter int unsigned SIZE_INSTR   = 32,
  parameter int unsigned MEM_DEPTH    = 256
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_step,
  input  logic                    i_if_id_write,
  input  logic                    i_flush,
  input  logic [SIZE_ADDR_PC-1:0] i_pc,
  input  logic [SIZE_ADDR_PC-1:0] i_pc_4,
  input  logic [SIZE_ADDR_PC-1:0] i_pc_8,
  input  logic                    i_load_start,
  input  logic                    i_load_valid,
  input  logic [7:0]              i_load_byte,
  output logic                    o_program_ready,
  output logic [SIZE_INSTR-1:0]   o_instr,
  output logic [SIZE_ADDR_PC-1:0] o_pc_4,
  output logic [SIZE_ADDR_PC-1:0] o_pc_8,
  output logic                    o_halt,
  output logic                    o_addr_err
);

  localparam int unsigned ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned IDX_W  = SIZE_ADDR_PC - 2;

  fetch_state_e            state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic [23:0]             asm_q, asm_d;
  logic [SIZE_INSTR-1:0]   instr_q, instr_d;
  logic [SIZE_ADDR_PC-1:0] pc4_q, pc4_d;
  logic [SIZE_ADDR_PC-1:0] pc8_q, pc8_d;
  logic                    halt_q, halt_d;

  logic [31:0]             load_word;
  logic                    mem_we;
  logic [IDX_W-1:0]        pc_idx;
  logic [ADDR_W-1:0]       rd_addr;
  logic [SIZE_INSTR-1:0]   rd_data;

  // The fourth byte completes the word on the same edge that writes it.
  assign load_word = {asm_q, i_load_byte};
  assign pc_idx    = i_pc[SIZE_ADDR_PC-1:2];
  assign rd_addr   = ADDR_W'(pc_idx % IDX_W'(MEM_DEPTH));

`ifdef IF_ADDR_CHECK_EN
  logic err_q, err_d;
  logic idx_oob;
  assign idx_oob    = (pc_idx >= IDX_W'(MEM_DEPTH));
  assign o_addr_err = err_q;
`else
  assign o_addr_err = 1'b0;
`endif

  instr_mem #(
    .SIZE_INSTR (SIZE_INSTR),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (ptr_q),
    .i_wdata (SIZE_INSTR'(load_word)),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    pc8_d   = pc8_q;
    halt_d  = halt_q;
    mem_we  = 1'b0;
`ifdef IF_ADDR_CHECK_EN
    err_d   = err_q;
`endif

    if (i_load_start) begin
      state_d = LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
`ifdef IF_ADDR_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        LOAD: begin
          if (i_load_valid) begin
            asm_d = {asm_q[15:0], i_load_byte};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BYTE_CNT_W'(3)) begin
              mem_we = 1'b1;
              ptr_d  = ptr_q + 1'b1;
              if (load_word == HALT || ptr_q == ADDR_W'(MEM_DEPTH - 1)) state_d = READY;
            end
          end
        end
        READY:   ;
        default: state_d = IDLE;
      endcase
    end

    // Flush outranks stall; outside READY the pipe is fed NOPs.
    if (i_step) begin
      if (state_q != READY || i_flush) begin
        instr_d = SIZE_INSTR'(NOP);
        pc4_d   = '0;
        pc8_d   = '0;
        halt_d  = 1'b0;
      end else if (i_if_id_write) begin
        instr_d = rd_data;
        pc4_d   = i_pc_4;
        pc8_d   = i_pc_8;
        halt_d  = (rd_data == SIZE_INSTR'(HALT));
`ifdef IF_ADDR_CHECK_EN
        if (idx_oob) begin
          instr_d = SIZE_INSTR'(NOP);
          pc4_d   = '0;
          pc8_d   = '0;
          halt_d  = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      pc8_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      pc8_q   <= pc8_d;
      halt_q  <= halt_d;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  assign o_program_ready = (state_q == READY);
  assign o_instr         = instr_q;
  assign o_pc_4          = pc4_q;
  assign o_pc_8          = pc8_q;
  assign o_halt          = halt_q;

endmodule
